cps_frame_packer: RTL and testbench

- Downstream consumer of the counts-per-second counter.
- Captures the 16-bit window count on each end-of-window strobe, tags it with an 8-bit sequence number and buffers it in a small FIFO.
- Serialises each buffered sample as a fixed byte frame over a valid/ready byte stream feeding the UART transmitter.

---
 rtl/cps_pkg.sv | 52 +++++
 rtl/cps_sample_fifo.sv | 81 ++++++++
 rtl/cps_frame_packer.sv | 169 ++++++++++++++++
 tb/tb_cps_frame_packer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cps_pkg.sv
// -----------------------------------------------------------------------------
// cps_pkg
// Shared definitions for the counts-per-second frame packer: FSM state
// encoding, frame length, sample entry layout and the checksum helper.
//
// Optional feature macro: CPS_FRAME_CSUM_EN
//   defined   -> 5-byte frame (HDR, SEQ, CHI, CLO, CSUM)
//   undefined -> 4-byte frame (HDR, SEQ, CHI, CLO)
// -----------------------------------------------------------------------------
package cps_pkg;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
  localparam int         ENTRY_W      = 24;

`ifdef CPS_FRAME_CSUM_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif

  // Byte states are numbered 1..FRAME_LEN in transmit order, so the state
  // value doubles as the 1-based byte index within the frame.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_SEQ  = 3'd2,
    ST_CHI  = 3'd3,
`ifdef CPS_FRAME_CSUM_EN
    ST_CLO  = 3'd4,
    ST_CSUM = 3'd5
`else
    ST_CLO  = 3'd4
`endif
  } state_e;

  // Final byte state of a frame; its handshake returns the FSM to idle.
  localparam state_e LAST_ST = state_e'(3'(FRAME_LEN));

  // One buffered sample: sequence tag in the top byte, window count below.
  typedef struct packed {
    logic [7:0]  seq;
    logic [15:0] cnt;
  } sample_t;

`ifdef CPS_FRAME_CSUM_EN
  // Header byte is deliberately excluded from the checksum.
  function automatic logic [7:0] frame_csum(input sample_t s);
    return s.seq ^ s.cnt[15:8] ^ s.cnt[7:0];
  endfunction
`endif

endpackage

// File: rtl/cps_sample_fifo.sv
// -----------------------------------------------------------------------------
// cps_sample_fifo
// Synchronous first-word-fall-through FIFO for captured samples.
// A push while full is accepted only when a pop happens in the same cycle
// (the slot being vacated is reused); otherwise it is ignored.
//
// Ports:
//   clk      system clock
//   reset    asynchronous, active-high reset (empties the FIFO)
//   i_push   write i_din this cycle
//   i_din    entry to write
//   i_pop    retire the head entry this cycle
//   o_dout   head entry (valid while o_empty is low)
//   o_full   no free slot
//   o_empty  no stored entry
// -----------------------------------------------------------------------------
module cps_sample_fifo
  import cps_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // NOTE: storage array has no reset; the count/pointers define validity, and
  // leaving it unreset lets it map onto plain RAM or register files.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // NOTE: all sequential state uses non-blocking assignment so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cps_frame_packer.sv
// -----------------------------------------------------------------------------
// cps_frame_packer
// Captures the 16-bit window count on each rising end-of-window strobe, tags
// it with an 8-bit wrapping sequence number, buffers it, and serialises each
// sample as a fixed byte frame on a valid/ready byte stream.
//
// Optional feature macro: CPS_FRAME_CSUM_EN (appends an XOR checksum byte).
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high reset
//   cnt_i     window count (stable while win_i is high)
//   win_i     end-of-window strobe (level; rising edge captures)
//   tx_data   frame byte
//   tx_valid  tx_data valid
//   tx_ready  sink accepts byte this cycle
//   overflow  sticky: a sample was dropped
//   ovf_clr   clears overflow (a same-cycle drop takes priority)
//   busy      frame in flight or FIFO non-empty
// -----------------------------------------------------------------------------
module cps_frame_packer
  import cps_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] HDR_BYTE   = HDR_BYTE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cnt_i,
  input  logic        win_i,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        overflow,
  input  logic        ovf_clr,
  output logic        busy
);

  state_e     r_state;
  state_e     w_state_next;
  logic       r_win_q;
  logic [7:0] r_seq;
  logic       r_ovf;
  sample_t    r_frame;

  logic       w_capture;
  logic       w_push;
  logic       w_pop;
  logic       w_drop;
  logic       w_full;
  logic       w_empty;
  sample_t    w_sample_in;
  sample_t    w_fifo_dout;

  // ---------------------------------------------------------------------------
  // Capture and sequence tagging
  // ---------------------------------------------------------------------------
  // Rising-edge detect so a strobe held for several cycles captures once.
  assign w_capture   = win_i & ~r_win_q;
  assign w_sample_in = '{seq: r_seq, cnt: cnt_i};

  // The FSM pops only from idle; a pop frees a slot for a same-cycle push.
  assign w_pop  = (r_state == ST_IDLE) & ~w_empty;
  assign w_push = w_capture & (~w_full | w_pop);
  assign w_drop = w_capture & ~w_push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win_q <= 1'b0;
      r_seq   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_win_q <= win_i;
      // Dropped samples still consume a sequence number so the host sees the gap.
      if (w_capture) begin
        r_seq <= r_seq + 8'd1;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign overflow = r_ovf;

  cps_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (w_sample_in),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // ---------------------------------------------------------------------------
  // Frame serialiser
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_frame <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) begin
        r_frame <= w_fifo_dout;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;

    case (r_state)
      ST_IDLE: begin
        if (w_pop) begin
          w_state_next = ST_HDR;
        end
      end
      ST_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BYTE;
      end
      ST_SEQ: begin
        tx_valid = 1'b1;
        tx_data  = r_frame.seq;
      end
      ST_CHI: begin
        tx_valid = 1'b1;
        tx_data  = r_frame.cnt[15:8];
      end
      ST_CLO: begin
        tx_valid = 1'b1;
        tx_data  = r_frame.cnt[7:0];
      end
`ifdef CPS_FRAME_CSUM_EN
      ST_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = frame_csum(r_frame);
      end
`endif
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Byte states advance only on handshake; the data above stays put until then.
    if (tx_valid && tx_ready) begin
      if (r_state == LAST_ST) begin
        w_state_next = ST_IDLE;
      end else begin
        w_state_next = state_e'(r_state + 3'd1);
      end
    end
  end

  assign busy = (r_state != ST_IDLE) | ~w_empty;

endmodule

// File: tb/tb_cps_frame_packer.sv
// -----------------------------------------------------------------------------
// tb_cps_frame_packer
// Directed stimulus pushes expected frame bytes into a scoreboard queue; a
// monitor on the falling edge pops and compares every accepted byte and checks
// that a stalled byte is held unchanged.
// -----------------------------------------------------------------------------
module tb_cps_frame_packer;

  localparam logic [7:0] HDR = 8'hA5;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cnt_i;
  logic        win_i;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        overflow;
  logic        ovf_clr;
  logic        busy;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  sb [$];
  logic [7:0]  exp_seq;
  bit          bp_mode = 1'b0;
  logic        rdy_level = 1'b0;

  cps_frame_packer #(
    .FIFO_DEPTH (4),
    .HDR_BYTE   (8'hA5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cnt_i    (cnt_i),
    .win_i    (win_i),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Sink readiness: either a fixed level or toggling every cycle.
  always @(posedge clk) begin
    #1;
    tx_ready = bp_mode ? ~tx_ready : rdy_level;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_frame(input logic [7:0] s, input logic [15:0] c);
    sb.push_back(HDR);
    sb.push_back(s);
    sb.push_back(c[15:8]);
    sb.push_back(c[7:0]);
`ifdef CPS_FRAME_CSUM_EN
    sb.push_back(s ^ c[15:8] ^ c[7:0]);
`endif
  endtask

  // Raise win_i for 'hold' edges; 'kept' says whether the bench expects the
  // sample to reach the FIFO, 'clr' drives ovf_clr on the capture edge.
  task automatic strobe(input logic [15:0] c, input int hold, input bit kept, input bit clr);
    @(posedge clk);
    #1;
    cnt_i   = c;
    win_i   = 1'b1;
    ovf_clr = clr;
    if (kept) expect_frame(exp_seq, c);
    exp_seq = exp_seq + 8'd1;
    repeat (hold) @(posedge clk);
    #1;
    win_i   = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int i;
    i = 0;
    while ((busy || sb.size() != 0) && i < 400) begin
      @(posedge clk);
      #1;
      i++;
    end
    check({name, "_queue_empty"}, sb.size(), 0);
    check({name, "_idle"}, busy, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    exp_seq = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: compare accepted bytes against the scoreboard, check stalls hold.
  logic [7:0] prev_data;
  bit         prev_pend = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        check("stall_valid_held", tx_valid, 1'b1);
        check("stall_data_held", tx_data, prev_data);
      end
      if (tx_valid && tx_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_byte: got %02h, expected no byte at %0t", tx_data, $time);
        end else begin
          check("frame_byte", tx_data, sb.pop_front());
        end
        prev_pend = 1'b0;
      end else if (tx_valid) begin
        prev_pend = 1'b1;
        prev_data = tx_data;
      end else begin
        prev_pend = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b1;
    win_i   = 1'b0;
    cnt_i   = 16'h0000;
    ovf_clr = 1'b0;
    exp_seq = 8'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_overflow", overflow, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;

    // Single sample: A5 00 12 34 (+26), valid two edges after the strobe
    rdy_level = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cnt_i = 16'h1234;
    win_i = 1'b1;
    sb.push_back(8'hA5);
    sb.push_back(8'h00);
    sb.push_back(8'h12);
    sb.push_back(8'h34);
`ifdef CPS_FRAME_CSUM_EN
    sb.push_back(8'h26);
`endif
    exp_seq = 8'd1;
    @(posedge clk);                       // capture edge N
    #1;
    win_i = 1'b0;
    check("lat_valid_after_N", tx_valid, 1'b0);
    check("lat_busy_after_N", busy, 1'b1);
    @(posedge clk);                       // pop edge N+1
    #1;
    check("lat_valid_after_N1", tx_valid, 1'b1);
    check("lat_hdr_after_N1", tx_data, 8'hA5);
    wait_drain("single");

    // Backpressure: ready toggles; two queued frames
    bp_mode = 1'b1;
    strobe(16'hABCD, 1, 1'b1, 1'b0);
    strobe(16'h0F0F, 1, 1'b1, 1'b0);
    wait_drain("backpressure");
    bp_mode = 1'b0;
    repeat (2) @(posedge clk);

    // Held strobe: five cycles high yields exactly one frame
    strobe(16'h00FF, 5, 1'b1, 1'b0);
    wait_drain("held");
    repeat (4) @(posedge clk);
    check("held_no_extra", sb.size(), 0);

    // Reset during the CHI byte
    @(posedge clk);
    #1;
    cnt_i = 16'h5678;
    win_i = 1'b1;
    expect_frame(exp_seq, 16'h5678);
    @(posedge clk);                       // capture N
    #1;
    win_i = 1'b0;
    repeat (3) @(posedge clk);            // N+1 HDR, N+2 SEQ, N+3 CHI
    #1;
    check("mid_at_chi_valid", tx_valid, 1'b1);
    check("mid_at_chi_data", tx_data, 8'h56);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_valid_drop", tx_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    do_reset();
    strobe(16'h9ABC, 1, 1'b1, 1'b0);      // carries seq 00
    wait_drain("after_reset");

    // Overflow: frame register takes sample 1, FIFO holds 2..5, 6 is dropped
    do_reset();
    rdy_level = 1'b0;
    repeat (3) @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      strobe(16'(k), 1, 1'b1, 1'b0);
    end
    check("ovf_not_yet", overflow, 1'b0);
    strobe(16'h0006, 1, 1'b0, 1'b0);
    check("ovf_set", overflow, 1'b1);
    rdy_level = 1'b1;
    wait_drain("ovf_drain");
    strobe(16'h0007, 1, 1'b1, 1'b0);      // seq 06 after the gap
    wait_drain("ovf_next_seq");
    check("ovf_sticky", overflow, 1'b1);

    // ovf_clr alone, then a clear coinciding with a drop, then clear again
    @(posedge clk);
    #1;
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    check("clr_alone_1", overflow, 1'b0);
    rdy_level = 1'b0;
    repeat (3) @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      strobe(16'hC000 + 16'(k), 1, 1'b1, 1'b0);
    end
    check("clr_pre_drop", overflow, 1'b0);
    strobe(16'hC0FF, 1, 1'b0, 1'b1);
    check("clr_drop_wins", overflow, 1'b1);
    @(posedge clk);
    #1;
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    check("clr_alone_2", overflow, 1'b0);
    rdy_level = 1'b1;
    wait_drain("clr_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
